// File: rtl/basic_control_sequencer_if.sv
// Bundles the sequencer's instruction/handshake inputs and its timing and
// control-strobe outputs.
//   master : drives run, ir, exec_done; observes timing, decode and strobes
//   slave  : the sequencer itself (inverse directions)
interface basic_control_sequencer_if;
  logic        run;
  logic [15:0] ir;
  logic        exec_done;
  logic [15:0] t;
  logic [7:0]  d;
  logic        i_bit;
  logic        ar_ld_pc;
  logic        ir_ld_mem;
  logic        pc_inc;
  logic        ar_ld_ir;
  logic        ar_ld_mem;
  logic        rr_exec;
  logic        io_exec;
  logic        mr_exec;
  logic        halted;
  logic        sc_err;

  modport master (
    output run, ir, exec_done,
    input  t, d, i_bit, ar_ld_pc, ir_ld_mem, pc_inc, ar_ld_ir, ar_ld_mem,
           rr_exec, io_exec, mr_exec, halted, sc_err
  );

  modport slave (
    input  run, ir, exec_done,
    output t, d, i_bit, ar_ld_pc, ir_ld_mem, pc_inc, ar_ld_ir, ar_ld_mem,
           rr_exec, io_exec, mr_exec, halted, sc_err
  );
endinterface

// File: rtl/basic_control_sequencer.sv
// Timing and control sequencer for the basic computer.
// Holds the start/stop flip-flop S, the 4-bit sequence counter SC, the
// addressing-mode flip-flop I and a sticky SC-overflow flag. Produces
// one-hot timing T0..T15, the opcode decode D0..D7 and the fetch/decode/
// indirect/execute control strobes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of basic_control_sequencer_if
//           (in: run, ir, exec_done; out: t, d, i_bit, strobes, halted, sc_err)
module basic_control_sequencer (
  input  logic                            clk,
  input  logic                            rst_n,
  basic_control_sequencer_if.slave        bus
);

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  run_state_e  s_q, s_d;
  logic [3:0]  sc_q, sc_d;
  logic        i_q, i_d;
  logic        err_q, err_d;

  logic [15:0] t_w;
  logic [7:0]  d_w;
  logic        d7;
  logic        rr_exec_w;
  logic        mr_exec_w;
  logic        hlt;
  logic        sc_clr;

  // Timing decode of SC, gated by S; opcode decode of IR[14:12].
  always_comb begin
    t_w = '0;
    if (s_q == ST_RUN) t_w[sc_q] = 1'b1;
    d_w = '0;
    d_w[bus.ir[14:12]] = 1'b1;
  end

  assign d7        = d_w[7];
  assign rr_exec_w = d7 & ~i_q & t_w[3];
  assign mr_exec_w = ~d7 & (|t_w[15:4]);
  assign hlt       = rr_exec_w & bus.ir[0];
  // Any clear source beats the SC=15 wrap, so exec_done at T15 never
  // raises sc_err.
  assign sc_clr    = (d7 & t_w[3]) | (bus.exec_done & mr_exec_w) | hlt;

  always_comb begin
    s_d   = s_q;
    sc_d  = sc_q;
    i_d   = i_q;
    err_d = err_q;
    unique case (s_q)
      ST_HALT: begin
        sc_d = '0;
        if (bus.run) s_d = ST_RUN;
      end
      ST_RUN: begin
        if (hlt) s_d = ST_HALT;
        if (sc_clr) begin
          sc_d = '0;
        end else begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'hF) err_d = 1'b1;
        end
        if (t_w[2]) i_d = bus.ir[15];
      end
      default: s_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= ST_HALT;
      sc_q  <= '0;
      i_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      sc_q  <= sc_d;
      i_q   <= i_d;
      err_q <= err_d;
    end
  end

  assign bus.t         = t_w;
  assign bus.d         = d_w;
  assign bus.i_bit     = i_q;
  assign bus.ar_ld_pc  = t_w[0];
  assign bus.ir_ld_mem = t_w[1];
  assign bus.pc_inc    = t_w[1];
  assign bus.ar_ld_ir  = t_w[2];
  assign bus.ar_ld_mem = ~d7 & i_q & t_w[3];
  assign bus.rr_exec   = rr_exec_w;
  assign bus.io_exec   = d7 & i_q & t_w[3];
  assign bus.mr_exec   = mr_exec_w;
  assign bus.halted    = (s_q == ST_HALT);
  assign bus.sc_err    = err_q;

endmodule

// File: tb/tb_basic_control_sequencer.sv
module tb_basic_control_sequencer;

  logic clk;
  logic rst_n;

  basic_control_sequencer_if bus ();

  basic_control_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe vector layout:
  // {ar_ld_pc, ir_ld_mem, pc_inc, ar_ld_ir, ar_ld_mem, rr_exec, io_exec, mr_exec, halted}
  localparam logic [8:0] S_N  = 9'b000000000;
  localparam logic [8:0] S_P  = 9'b100000000;
  localparam logic [8:0] S_F  = 9'b011000000;
  localparam logic [8:0] S_A  = 9'b000100000;
  localparam logic [8:0] S_M  = 9'b000010000;
  localparam logic [8:0] S_R  = 9'b000001000;
  localparam logic [8:0] S_IO = 9'b000000100;
  localparam logic [8:0] S_X  = 9'b000000010;
  localparam logic [8:0] S_H  = 9'b000000001;

  typedef struct {
    logic        run;
    logic [15:0] ir;
    logic        ed;
    logic [15:0] t;
    logic [8:0]  str;
    logic [7:0]  d;
    logic        ib;
  } vec_t;

  vec_t vq[$];

  function automatic logic [8:0] strobes();
    return {bus.ar_ld_pc, bus.ir_ld_mem, bus.pc_inc, bus.ar_ld_ir, bus.ar_ld_mem,
            bus.rr_exec, bus.io_exec, bus.mr_exec, bus.halted};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic run, input logic [15:0] ir, input logic ed,
                     input logic [15:0] t, input logic [8:0] str,
                     input logic [7:0] d, input logic ib);
    vq.push_back('{run, ir, ed, t, str, d, ib});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.exec_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [15:0] e_t;

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.ir = 16'h2005;
    bus.exec_done = 1'b0;

    // Direct LDA, indirect ADD, register-ref, HLT, restart with I/O.
    add(1, 16'h2005, 0, 16'h0000, S_H,  8'h04, 0);
    add(0, 16'h2005, 0, 16'h0001, S_P,  8'h04, 0);
    add(0, 16'h2005, 0, 16'h0002, S_F,  8'h04, 0);
    add(0, 16'h2005, 0, 16'h0004, S_A,  8'h04, 0);
    add(0, 16'h2005, 0, 16'h0008, S_N,  8'h04, 0);
    add(0, 16'h2005, 0, 16'h0010, S_X,  8'h04, 0);
    add(0, 16'h2005, 1, 16'h0020, S_X,  8'h04, 0);
    add(0, 16'h9005, 0, 16'h0001, S_P,  8'h02, 0);
    add(0, 16'h9005, 0, 16'h0002, S_F,  8'h02, 0);
    add(0, 16'h9005, 0, 16'h0004, S_A,  8'h02, 0);
    add(0, 16'h9005, 1, 16'h0008, S_M,  8'h02, 1);
    add(0, 16'h9005, 0, 16'h0010, S_X,  8'h02, 1);
    add(0, 16'h9005, 0, 16'h0020, S_X,  8'h02, 1);
    add(0, 16'h9005, 1, 16'h0040, S_X,  8'h02, 1);
    add(0, 16'h7800, 0, 16'h0001, S_P,  8'h80, 1);
    add(0, 16'h7800, 0, 16'h0002, S_F,  8'h80, 1);
    add(0, 16'h7800, 0, 16'h0004, S_A,  8'h80, 1);
    add(0, 16'h7800, 0, 16'h0008, S_R,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0001, S_P,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0002, S_F,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0004, S_A,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0008, S_R,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0000, S_H,  8'h80, 0);
    add(0, 16'h7001, 0, 16'h0000, S_H,  8'h80, 0);
    add(1, 16'hF002, 0, 16'h0000, S_H,  8'h80, 0);
    add(0, 16'hF002, 0, 16'h0001, S_P,  8'h80, 0);
    add(0, 16'hF002, 0, 16'h0002, S_F,  8'h80, 0);
    add(0, 16'hF002, 0, 16'h0004, S_A,  8'h80, 0);
    add(0, 16'hF002, 0, 16'h0008, S_IO, 8'h80, 1);
    add(1, 16'hF002, 0, 16'h0001, S_P,  8'h80, 1);

    // Reset state with ir=2005.
    step();
    step();
    chk("rst t", bus.t, 16'h0000);
    chk("rst halted", {15'd0, bus.halted}, 16'd1);
    chk("rst sc_err", {15'd0, bus.sc_err}, 16'd0);
    chk("rst d", {8'd0, bus.d}, 16'h0004);
    chk("rst i_bit", {15'd0, bus.i_bit}, 16'd0);
    chk("rst strobes", {7'd0, strobes()}, {7'd0, S_H});
    rst_n = 1'b1;
    step();
    chk("idle t0", bus.t, 16'h0000);
    step();
    chk("idle t1", bus.t, 16'h0000);

    foreach (vq[k]) begin
      bus.run = vq[k].run;
      bus.ir = vq[k].ir;
      bus.exec_done = vq[k].ed;
      #1;
      chk($sformatf("v%0d t", k), bus.t, vq[k].t);
      chk($sformatf("v%0d strobes", k), {7'd0, strobes()}, {7'd0, vq[k].str});
      chk($sformatf("v%0d d", k), {8'd0, bus.d}, {8'd0, vq[k].d});
      chk($sformatf("v%0d i_bit", k), {15'd0, bus.i_bit}, {15'd0, vq[k].ib});
      chk($sformatf("v%0d sc_err", k), {15'd0, bus.sc_err}, 16'd0);
      step();
    end

    // Reset mid-fetch: now in T1 with i_bit=1 left by the I/O instruction.
    bus.run = 1'b0;
    bus.ir = 16'h8005;
    #1;
    chk("mf T1", bus.t, 16'h0002);
    step();
    chk("mf T2", bus.t, 16'h0004);
    chk("mf T2 i_bit", {15'd0, bus.i_bit}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mf async t", bus.t, 16'h0000);
    chk("mf async i_bit", {15'd0, bus.i_bit}, 16'd0);
    chk("mf async strobes", {7'd0, strobes()}, {7'd0, S_H});
    #1;
    rst_n = 1'b1;
    step();
    chk("mf idle", bus.t, 16'h0000);
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    #1;
    chk("mf restart T0", bus.t, 16'h0001);

    // run and HLT in the same cycle: HLT wins.
    bus.ir = 16'h7001;
    step();
    step();
    step();
    chk("hr T3", bus.t, 16'h0008);
    chk("hr rr_exec", {15'd0, bus.rr_exec}, 16'd1);
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    chk("hr halted", {15'd0, bus.halted}, 16'd1);
    chk("hr t", bus.t, 16'h0000);

    // Overflow: memory-reference with no exec_done.
    do_reset();
    bus.ir = 16'h1005;
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e_t = 16'h0001 << k;
      #1;
      chk($sformatf("ov T%0d", k), bus.t, e_t);
      chk($sformatf("ov T%0d err", k), {15'd0, bus.sc_err}, 16'd0);
      step();
    end
    chk("ov wrap t", bus.t, 16'h0001);
    chk("ov wrap err", {15'd0, bus.sc_err}, 16'd1);
    step();
    step();
    step();
    step();
    chk("ov2 T4", bus.t, 16'h0010);
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    chk("ov2 T0", bus.t, 16'h0001);
    chk("ov2 err sticky", {15'd0, bus.sc_err}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("ov rst err", {15'd0, bus.sc_err}, 16'd0);

    // exec_done at T15 beats the wrap.
    do_reset();
    bus.ir = 16'h1005;
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    for (int k = 0; k < 15; k++) step();
    chk("p15 T15", bus.t, 16'h8000);
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    chk("p15 T0", bus.t, 16'h0001);
    chk("p15 err", {15'd0, bus.sc_err}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
